pipeline_id_ex_reg: RTL and testbench

ID/EX pipeline register of the 5-stage MIPS pipeline: the consuming end of the hazard unit's `ID_EX_clear`/`ID_EX_stall` controls, and the source of the `ID_EX_MEMRd`, `ID_EX_Rt` and `ID_EX_PCSrc` signals the hazard unit reads back. Each cycle it either latches the decoded ID-stage bundle, inserts a bubble, or holds its contents. While holding, it refreshes the held operands from the WB write port. It also keeps saturating bubble, hold and issue counters for performance debug.

---
 rtl/pipeline_id_ex_reg.sv | 121 ++++++++++++
 tb/tb_pipeline_id_ex_reg.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_id_ex_reg.sv
// ID/EX pipeline register: per-cycle reset / bubble / hold / load with WB refresh
// of held operands and saturating bubble, hold and issue counters.
module pipeline_id_ex_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_clear,
  input  logic             ID_EX_stall,
  input  logic [2:0]       ID_PCSrc,
  input  logic             ID_MemRd,
  input  logic             ID_MemWr,
  input  logic             ID_RegWr,
  input  logic             ID_ALUSrc1,
  input  logic             ID_ALUSrc2,
  input  logic             ID_Sign,
  input  logic [1:0]       ID_MemToReg,
  input  logic [1:0]       ID_RegDst,
  input  logic [5:0]       ID_ALUFun,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic [4:0]       ID_Rd,
  input  logic [4:0]       ID_Shamt,
  input  logic [31:0]      ID_BusA,
  input  logic [31:0]      ID_BusB,
  input  logic [31:0]      ID_Imm32,
  input  logic [31:0]      ID_PC4,
  input  logic             WB_RegWr,
  input  logic [4:0]       WB_Rd,
  input  logic [31:0]      WB_Data,
  output logic [2:0]       ID_EX_PCSrc,
  output logic             ID_EX_MemRd,
  output logic             ID_EX_MemWr,
  output logic             ID_EX_RegWr,
  output logic             ID_EX_ALUSrc1,
  output logic             ID_EX_ALUSrc2,
  output logic             ID_EX_Sign,
  output logic [1:0]       ID_EX_MemToReg,
  output logic [1:0]       ID_EX_RegDst,
  output logic [5:0]       ID_EX_ALUFun,
  output logic [4:0]       ID_EX_Rs,
  output logic [4:0]       ID_EX_Rt,
  output logic [4:0]       ID_EX_Rd,
  output logic [4:0]       ID_EX_Shamt,
  output logic [31:0]      ID_EX_BusA,
  output logic [31:0]      ID_EX_BusB,
  output logic [31:0]      ID_EX_Imm32,
  output logic [31:0]      ID_EX_PC4,
  output logic             ID_EX_Valid,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] hold_cnt,
  output logic [CNT_W-1:0] issue_cnt
);

  logic wb_hit;
  assign wb_hit = ID_EX_Valid && WB_RegWr && (WB_Rd != 5'd0);

  always_ff @(posedge clk) begin
    if (reset || !ID_EX_clear) begin
      // a bubble is an all-zero bundle, which decodes as a NOP
      ID_EX_PCSrc    <= '0;
      ID_EX_MemRd    <= 1'b0;
      ID_EX_MemWr    <= 1'b0;
      ID_EX_RegWr    <= 1'b0;
      ID_EX_ALUSrc1  <= 1'b0;
      ID_EX_ALUSrc2  <= 1'b0;
      ID_EX_Sign     <= 1'b0;
      ID_EX_MemToReg <= '0;
      ID_EX_RegDst   <= '0;
      ID_EX_ALUFun   <= '0;
      ID_EX_Rs       <= '0;
      ID_EX_Rt       <= '0;
      ID_EX_Rd       <= '0;
      ID_EX_Shamt    <= '0;
      ID_EX_BusA     <= '0;
      ID_EX_BusB     <= '0;
      ID_EX_Imm32    <= '0;
      ID_EX_PC4      <= '0;
      ID_EX_Valid    <= 1'b0;
    end else if (!ID_EX_stall) begin
      // held operands would otherwise go stale while WB retires their producer
      if (wb_hit && WB_Rd == ID_EX_Rs) ID_EX_BusA <= WB_Data;
      if (wb_hit && WB_Rd == ID_EX_Rt) ID_EX_BusB <= WB_Data;
    end else begin
      ID_EX_PCSrc    <= ID_PCSrc;
      ID_EX_MemRd    <= ID_MemRd;
      ID_EX_MemWr    <= ID_MemWr;
      ID_EX_RegWr    <= ID_RegWr;
      ID_EX_ALUSrc1  <= ID_ALUSrc1;
      ID_EX_ALUSrc2  <= ID_ALUSrc2;
      ID_EX_Sign     <= ID_Sign;
      ID_EX_MemToReg <= ID_MemToReg;
      ID_EX_RegDst   <= ID_RegDst;
      ID_EX_ALUFun   <= ID_ALUFun;
      ID_EX_Rs       <= ID_Rs;
      ID_EX_Rt       <= ID_Rt;
      ID_EX_Rd       <= ID_Rd;
      ID_EX_Shamt    <= ID_Shamt;
      ID_EX_BusA     <= ID_BusA;
      ID_EX_BusB     <= ID_BusB;
      ID_EX_Imm32    <= ID_Imm32;
      ID_EX_PC4      <= ID_PC4;
      ID_EX_Valid    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
      issue_cnt  <= '0;
    end else if (!ID_EX_clear) begin
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end else if (!ID_EX_stall) begin
      if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
    end else begin
      if (issue_cnt != '1) issue_cnt <= issue_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_id_ex_reg.sv
// Bench for pipeline_id_ex_reg: a reference model predicts every cycle's register
// state into a scoreboard queue; scenario tasks pop and compare after each edge.
module tb_pipeline_id_ex_reg;

  typedef struct packed {
    logic [2:0]  pcsrc;
    logic        memrd, memwr, regwr, alusrc1, alusrc2, sign;
    logic [1:0]  memtoreg, regdst;
    logic [5:0]  alufun;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] busa, busb, imm, pc4;
    logic        valid;
    logic [15:0] bub, hold, issue;
  } st_t;

  logic clk = 1'b0;
  logic reset = 1'b1, clear = 1'b1, stall = 1'b1;
  logic [2:0] i_pcsrc;
  logic i_memrd, i_memwr, i_regwr, i_als1, i_als2, i_sign;
  logic [1:0] i_m2r, i_rdst;
  logic [5:0] i_fun;
  logic [4:0] i_rs, i_rt, i_rd, i_sh;
  logic [31:0] i_busa, i_busb, i_imm, i_pc4;
  logic wb_regwr;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;

  logic [2:0] o_pcsrc;
  logic o_memrd, o_memwr, o_regwr, o_als1, o_als2, o_sign, o_valid;
  logic [1:0] o_m2r, o_rdst;
  logic [5:0] o_fun;
  logic [4:0] o_rs, o_rt, o_rd, o_sh;
  logic [31:0] o_busa, o_busb, o_imm, o_pc4;
  logic [15:0] o_bub, o_hold, o_issue;

  logic [2:0] s_pcsrc;
  logic s_memrd, s_memwr, s_regwr, s_als1, s_als2, s_sign, s_valid;
  logic [1:0] s_m2r, s_rdst;
  logic [5:0] s_fun;
  logic [4:0] s_rs, s_rt, s_rd, s_sh;
  logic [31:0] s_busa, s_busb, s_imm, s_pc4;
  logic [2:0] s_bub, s_hold, s_issue;

  int checks = 0, errors = 0;
  st_t mdl = '0;
  st_t sb[$];
  st_t e, g;

  always #5 clk = ~clk;

  pipeline_id_ex_reg #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ID_EX_clear(clear), .ID_EX_stall(stall),
    .ID_PCSrc(i_pcsrc), .ID_MemRd(i_memrd), .ID_MemWr(i_memwr), .ID_RegWr(i_regwr),
    .ID_ALUSrc1(i_als1), .ID_ALUSrc2(i_als2), .ID_Sign(i_sign), .ID_MemToReg(i_m2r),
    .ID_RegDst(i_rdst), .ID_ALUFun(i_fun), .ID_Rs(i_rs), .ID_Rt(i_rt), .ID_Rd(i_rd),
    .ID_Shamt(i_sh), .ID_BusA(i_busa), .ID_BusB(i_busb), .ID_Imm32(i_imm), .ID_PC4(i_pc4),
    .WB_RegWr(wb_regwr), .WB_Rd(wb_rd), .WB_Data(wb_data),
    .ID_EX_PCSrc(o_pcsrc), .ID_EX_MemRd(o_memrd), .ID_EX_MemWr(o_memwr), .ID_EX_RegWr(o_regwr),
    .ID_EX_ALUSrc1(o_als1), .ID_EX_ALUSrc2(o_als2), .ID_EX_Sign(o_sign), .ID_EX_MemToReg(o_m2r),
    .ID_EX_RegDst(o_rdst), .ID_EX_ALUFun(o_fun), .ID_EX_Rs(o_rs), .ID_EX_Rt(o_rt), .ID_EX_Rd(o_rd),
    .ID_EX_Shamt(o_sh), .ID_EX_BusA(o_busa), .ID_EX_BusB(o_busb), .ID_EX_Imm32(o_imm),
    .ID_EX_PC4(o_pc4), .ID_EX_Valid(o_valid),
    .bubble_cnt(o_bub), .hold_cnt(o_hold), .issue_cnt(o_issue)
  );

  pipeline_id_ex_reg #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .ID_EX_clear(clear), .ID_EX_stall(stall),
    .ID_PCSrc(i_pcsrc), .ID_MemRd(i_memrd), .ID_MemWr(i_memwr), .ID_RegWr(i_regwr),
    .ID_ALUSrc1(i_als1), .ID_ALUSrc2(i_als2), .ID_Sign(i_sign), .ID_MemToReg(i_m2r),
    .ID_RegDst(i_rdst), .ID_ALUFun(i_fun), .ID_Rs(i_rs), .ID_Rt(i_rt), .ID_Rd(i_rd),
    .ID_Shamt(i_sh), .ID_BusA(i_busa), .ID_BusB(i_busb), .ID_Imm32(i_imm), .ID_PC4(i_pc4),
    .WB_RegWr(wb_regwr), .WB_Rd(wb_rd), .WB_Data(wb_data),
    .ID_EX_PCSrc(s_pcsrc), .ID_EX_MemRd(s_memrd), .ID_EX_MemWr(s_memwr), .ID_EX_RegWr(s_regwr),
    .ID_EX_ALUSrc1(s_als1), .ID_EX_ALUSrc2(s_als2), .ID_EX_Sign(s_sign), .ID_EX_MemToReg(s_m2r),
    .ID_EX_RegDst(s_rdst), .ID_EX_ALUFun(s_fun), .ID_EX_Rs(s_rs), .ID_EX_Rt(s_rt), .ID_EX_Rd(s_rd),
    .ID_EX_Shamt(s_sh), .ID_EX_BusA(s_busa), .ID_EX_BusB(s_busb), .ID_EX_Imm32(s_imm),
    .ID_EX_PC4(s_pc4), .ID_EX_Valid(s_valid),
    .bubble_cnt(s_bub), .hold_cnt(s_hold), .issue_cnt(s_issue)
  );

  function automatic logic [15:0] sat(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  function automatic st_t sample();
    st_t s;
    s = '{o_pcsrc, o_memrd, o_memwr, o_regwr, o_als1, o_als2, o_sign, o_m2r, o_rdst, o_fun,
          o_rs, o_rt, o_rd, o_sh, o_busa, o_busb, o_imm, o_pc4, o_valid, o_bub, o_hold, o_issue};
    return s;
  endfunction

  function automatic st_t predict();
    st_t n = mdl;
    if (reset) n = '0;
    else if (!clear) begin
      n = '0; n.bub = sat(mdl.bub); n.hold = mdl.hold; n.issue = mdl.issue;
    end else if (!stall) begin
      n.hold = sat(mdl.hold);
      if (mdl.valid && wb_regwr && wb_rd != 5'd0) begin
        if (wb_rd == mdl.rs) n.busa = wb_data;
        if (wb_rd == mdl.rt) n.busb = wb_data;
      end
    end else begin
      n = '{i_pcsrc, i_memrd, i_memwr, i_regwr, i_als1, i_als2, i_sign, i_m2r, i_rdst, i_fun,
            i_rs, i_rt, i_rd, i_sh, i_busa, i_busb, i_imm, i_pc4, 1'b1,
            mdl.bub, mdl.hold, sat(mdl.issue)};
    end
    return n;
  endfunction

  task automatic rand_bundle();
    i_pcsrc = 3'($urandom); i_memrd = 1'($urandom); i_memwr = 1'($urandom);
    i_regwr = 1'($urandom); i_als1 = 1'($urandom); i_als2 = 1'($urandom);
    i_sign = 1'($urandom); i_m2r = 2'($urandom); i_rdst = 2'($urandom);
    i_fun = 6'($urandom); i_rs = 5'($urandom); i_rt = 5'($urandom);
    i_rd = 5'($urandom); i_sh = 5'($urandom); i_busa = $urandom; i_busb = $urandom;
    i_imm = $urandom; i_pc4 = $urandom;
  endtask

  task automatic tick();
    st_t n;
    n = predict();
    sb.push_back(n);
    mdl = n;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rand_bundle();
    i_pcsrc = 3'b111; i_memrd = 1; i_memwr = 1; i_regwr = 1; i_busa = 32'hFFFF_0001;
    wb_regwr = 1; wb_rd = 5'd9; wb_data = 32'hCAFE;
    clear = 1; stall = 1; reset = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset[%0d]: got %h want %h", k, g, e); end
    end
    checks++;
    if (o_pcsrc !== 3'b000 || o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_pcsrc_valid: got %b/%b want 000/0", o_pcsrc, o_valid);
    end
    reset = 0; wb_regwr = 0;
  endtask

  task automatic test_load();
    rand_bundle();
    i_rt = 5'd5; i_memrd = 1; i_busa = 32'h1234;
    tick();
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL load: got %h want %h", g, e); end
    checks++;
    if (o_rt !== 5'd5 || o_memrd !== 1'b1 || o_busa !== 32'h1234 || o_valid !== 1'b1 || o_issue !== 16'd1) begin
      errors++;
      $display("FAIL load_fields: got rt=%0d memrd=%b busa=%h valid=%b issue=%0d want 5 1 1234 1 1",
               o_rt, o_memrd, o_busa, o_valid, o_issue);
    end
  endtask

  task automatic test_bubble();
    clear = 0;
    tick();
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL bubble: got %h want %h", g, e); end
    checks++;
    if (o_regwr !== 0 || o_memrd !== 0 || o_memwr !== 0 || o_valid !== 0 || o_bub !== 16'd1) begin
      errors++;
      $display("FAIL bubble_nop: got regwr=%b memrd=%b memwr=%b valid=%b bub=%0d want 0 0 0 0 1",
               o_regwr, o_memrd, o_memwr, o_valid, o_bub);
    end
    clear = 1; rand_bundle();
    tick();
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL bubble_reload: got %h want %h", g, e); end
  endtask

  task automatic test_hold_refresh();
    rand_bundle();
    i_rs = 5'd3; i_rt = 5'd3; i_busa = 32'h11; i_busb = 32'h11;
    tick();
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL hold_load: got %h want %h", g, e); end
    stall = 0; wb_regwr = 1; wb_rd = 5'd3; wb_data = 32'hBEEF; rand_bundle();
    tick();
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL hold_refresh: got %h want %h", g, e); end
    checks++;
    if (o_busa !== 32'hBEEF || o_busb !== 32'hBEEF || o_hold !== 16'd1) begin
      errors++; $display("FAIL hold_beef: got %h %h hold=%0d want beef beef 1", o_busa, o_busb, o_hold);
    end
    wb_rd = 5'd0; wb_data = 32'hDEAD;
    tick();
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL hold_rd0: got %h want %h", g, e); end
    checks++;
    if (o_busa !== 32'hBEEF || o_busb !== 32'hBEEF) begin
      errors++; $display("FAIL hold_rd0_bus: got %h %h want beef beef", o_busa, o_busb);
    end
    // distinct Rs/Rt: only the matching bus refreshes
    stall = 1; wb_regwr = 0; rand_bundle(); i_rs = 5'd4; i_rt = 5'd7;
    tick();
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL hold_load2: got %h want %h", g, e); end
    stall = 0; wb_regwr = 1; wb_rd = 5'd7; wb_data = 32'h7777;
    tick();
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL hold_rt_only: got %h want %h", g, e); end
    stall = 1; wb_regwr = 0;
  endtask

  task automatic test_clear_and_stall();
    clear = 0; stall = 0;
    tick();
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL clear_stall: got %h want %h", g, e); end
    clear = 1; stall = 1;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      rand_bundle();
      clear = ($urandom_range(0, 4) != 0);
      stall = ($urandom_range(0, 2) != 0);
      wb_regwr = 1'($urandom);
      wb_rd = ($urandom_range(0, 1) != 0) ? mdl.rs : 5'($urandom);
      wb_data = $urandom;
      reset = (k == 25);
      tick();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL b2b[%0d]: got %h want %h", k, g, e); end
    end
    reset = 0; clear = 1; stall = 1; wb_regwr = 0;
  endtask

  task automatic test_saturation();
    reset = 1;
    tick();
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL sat_reset: got %h want %h", g, e); end
    reset = 0;
    for (int k = 1; k <= 10; k++) begin
      rand_bundle();
      tick();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL sat_main[%0d]: got %h want %h", k, g, e); end
      checks++;
      if (s_issue !== ((k > 7) ? 3'd7 : 3'(k))) begin
        errors++; $display("FAIL sat_issue[%0d]: got %0d want %0d", k, s_issue, (k > 7) ? 7 : k);
      end
    end
  endtask

  initial begin
    rand_bundle();
    wb_regwr = 0; wb_rd = 0; wb_data = 0;
    test_reset();
    test_load();
    test_bubble();
    test_hold_refresh();
    test_clear_and_stall();
    test_back_to_back();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
